// File: rtl/cla_16x16_if.sv
// cla_16x16_if -- operand/result bundle for the 16-bit carry-lookahead adder.
//   a, b  : 16-bit unsigned operands (master -> slave)
//   cin   : carry-in into bit 0      (master -> slave)
//   sum   : 17-bit registered result, sum[16] = carry-out (slave -> master)
interface cla_16x16_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH:0]   sum;

    modport master (output a, output b, output cin, input sum);
    modport slave  (input a, input b, input cin, output sum);
endinterface

// File: rtl/cla_16x16.sv
// cla_16x16 -- two-level carry-lookahead adder, 16-bit operands, registered
// 17-bit result (latency 1, a new operand pair accepted every cycle).
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears sum
//   bus  : cla_16x16_if.slave carrying a, b, cin in and sum out
// Four 4-bit lookahead groups each report group propagate/generate; a
// second-level unit forms all group carry-ins in parallel from those and cin.

// cla_group4 -- 4-bit lookahead group, usable standalone as a 4-bit adder.
//   x, y : 4-bit operands     ci : carry-in
//   s    : 4-bit sum          co : carry-out ({co,s} = x + y + ci)
//   pg   : group propagate    gg : group generate
module cla_group4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       pg,
    output logic       gg
);
    logic [3:0] p, g, c;

    assign p = x ^ y;
    assign g = x & y;

    // Every carry is a flat sum-of-products of ci and the bit p/g terms.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign pg = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

    assign s = p ^ c;
endmodule

module cla_16x16 #(
    parameter int WIDTH = 16,   // fixed: 4 groups x 4 bits
    parameter int GROUP = 4     // fixed
) (
    input  logic        clk,
    input  logic        rst,
    cla_16x16_if.slave  bus
);
    localparam int NGRP = WIDTH / GROUP;

    logic [NGRP-1:0][GROUP-1:0] grp_s;
    logic [NGRP-1:0]            grp_pg, grp_gg, grp_co;
    logic [NGRP:0]              gc;     // gc[i] = carry into group i, gc[NGRP] = C16
    logic [WIDTH:0]             sum_q;

    for (genvar i = 0; i < NGRP; i++) begin : g_grp
        cla_group4 u_grp (
            .x  (bus.a[i*GROUP +: GROUP]),
            .y  (bus.b[i*GROUP +: GROUP]),
            .ci (gc[i]),
            .s  (grp_s[i]),
            .co (grp_co[i]),
            .pg (grp_pg[i]),
            .gg (grp_gg[i])
        );
    end

    // Second-level lookahead: each group carry-in expanded directly from
    // cin and the group P/G, so nothing ripples between groups.
    assign gc[0] = bus.cin;
    assign gc[1] = grp_gg[0] | (grp_pg[0] & bus.cin);
    assign gc[2] = grp_gg[1] | (grp_pg[1] & grp_gg[0])
                 | (grp_pg[1] & grp_pg[0] & bus.cin);
    assign gc[3] = grp_gg[2] | (grp_pg[2] & grp_gg[1])
                 | (grp_pg[2] & grp_pg[1] & grp_gg[0])
                 | (grp_pg[2] & grp_pg[1] & grp_pg[0] & bus.cin);
    assign gc[4] = grp_gg[3] | (grp_pg[3] & grp_gg[2])
                 | (grp_pg[3] & grp_pg[2] & grp_gg[1])
                 | (grp_pg[3] & grp_pg[2] & grp_pg[1] & grp_gg[0])
                 | (grp_pg[3] & grp_pg[2] & grp_pg[1] & grp_pg[0] & bus.cin);

    // The per-group carry-outs are redundant with the second-level carries;
    // they only serve as a consistency check between the two levels.
    a_carry_agree: assert property (@(posedge clk) disable iff (rst)
        grp_co == gc[NGRP:1]);

    always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= {gc[NGRP], grp_s};
    end

    assign bus.sum = sum_q;
endmodule

// File: tb/tb_cla_16x16.sv
// tb_cla_16x16 -- directed and random checks of cla_16x16 plus an exhaustive
// sweep of the standalone 4-bit lookahead group.
module tb_cla_16x16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cla_16x16_if #(.WIDTH(16)) bus ();

    cla_16x16 #(.WIDTH(16), .GROUP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [3:0] gx, gy, gs;
    logic       gci, gco, gpg, ggg;

    cla_group4 u_g (
        .x  (gx),
        .y  (gy),
        .ci (gci),
        .s  (gs),
        .co (gco),
        .pg (gpg),
        .gg (ggg)
    );

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one operand set away from the edge, then check the registered
    // result just after the next rising edge.
    task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input string tag, input logic [16:0] exp);
        @(negedge clk);
        rst     = r;
        bus.a   = a;
        bus.b   = b;
        bus.cin = c;
        @(posedge clk);
        #1;
        chk(tag, bus.sum, exp);
    endtask

    initial begin
        logic [15:0] v, ra, rb;
        logic        rc;
        logic [3:0]  p, g;
        logic [4:0]  e5;
        logic        epg, egg;

        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        gx = '0; gy = '0; gci = 1'b0;

        // Reset overrides operands, then first result after release.
        step(1'b1, 16'h1234, 16'h4321, 1'b0, "reset", 17'h00000);
        step(1'b0, 16'h1234, 16'h4321, 1'b0, "post_reset", 17'h05555);

        // Doubling, low values.
        for (int i = 0; i < 16; i++) begin
            v = 16'(i);
            step(1'b0, v, v, 1'b0, "dbl_low", {v, 1'b0});
        end
        step(1'b0, 16'h000F, 16'h000F, 1'b0, "dbl_15", 17'h0001E);

        // Doubling, high values (exercise sum[16]).
        for (int i = 16'hFFF0; i <= 16'hFFFF; i++) begin
            v = 16'(i);
            step(1'b0, v, v, 1'b0, "dbl_high", {v, 1'b0});
        end
        step(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, "dbl_ffff", 17'h1FFFE);

        // Carry chain across all four groups and boundaries.
        step(1'b0, 16'hFFFF, 16'h0001, 1'b0, "chain_b1",  17'h10000);
        step(1'b0, 16'hFFFF, 16'h0000, 1'b1, "chain_cin", 17'h10000);
        step(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, "max",       17'h1FFFF);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, "zero",      17'h00000);
        step(1'b0, 16'h0FFF, 16'h0001, 1'b0, "chain_12",  17'h01000);
        step(1'b0, 16'h8000, 16'h8000, 1'b0, "msb_only",  17'h10000);

        // Reset mid-stream: no residue from before the reset.
        step(1'b0, 16'hAAAA, 16'h5555, 1'b1, "pre_rst",   17'h10000);
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "mid_rst",   17'h00000);
        step(1'b0, 16'h0100, 16'h0023, 1'b1, "after_rst", 17'h00124);

        // Exhaustive 4-bit group against the bit-level definitions.
        for (int c = 0; c < 2; c++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    gx = 4'(x); gy = 4'(y); gci = c[0];
                    #1;
                    e5  = 5'(x) + 5'(y) + 5'(c);
                    p   = gx ^ gy;
                    g   = gx & gy;
                    epg = p[0] & p[1] & p[2] & p[3];
                    egg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                        | (p[3] & p[2] & p[1] & g[0]);
                    chk("grp_sum", 17'({gco, gs}), 17'(e5));
                    chk("grp_pg",  17'(gpg), 17'(epg));
                    chk("grp_gg",  17'(ggg), 17'(egg));
                end
            end
        end
        gx = 4'hF; gy = 4'hF; gci = 1'b0;
        #1;
        chk("grp_f_f", 17'({gco, gs}), 17'h0001E);

        // Random back-to-back operands.
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom_range(0, 16'hFFFF));
            rb = 16'($urandom_range(0, 16'hFFFF));
            rc = 1'($urandom_range(0, 1));
            step(1'b0, ra, rb, rc, "random", {1'b0, ra} + {1'b0, rb} + 17'(rc));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
